// File: rtl/count_mon_pkg.sv
// Shared types for the counter monitor: FSM states, delta classes and the default step limit.
package count_mon_pkg;

   localparam int STEP_MAX_DEF = 15;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_SEED  = 2'd1,
      ST_ACQ   = 2'd2,
      ST_LOCK  = 2'd3
   } mon_state_e;

   typedef enum logic [1:0] {
      DC_HOLD = 2'd0,
      DC_UP   = 2'd1,
      DC_DOWN = 2'd2,
      DC_JUMP = 2'd3
   } delta_class_e;

endpackage

// File: rtl/count_monitor_if.sv
// Sample/observation bundle between a counter source and the count monitor.
interface count_monitor_if;

   logic       sample_en;
   logic [7:0] cin;
   logic       clr_err;
   logic [3:0] step;
   logic       dir;
   logic       locked;
   logic       err;
   logic       jump;
   logic       stall;
   logic [7:0] err_count;

   modport master (
      output sample_en, cin, clr_err,
      input  step, dir, locked, err, jump, stall, err_count
   );

   modport slave (
      input  sample_en, cin, clr_err,
      output step, dir, locked, err, jump, stall, err_count
   );

endinterface

// File: rtl/count_delta_class.sv
// Classifies the modulo-256 difference between two counter samples as hold, up, down or jump.
module count_delta_class
   import count_mon_pkg::*;
#(
   parameter int STEP_MAX = STEP_MAX_DEF
) (
   input  logic [7:0]   i_cin,
   input  logic [7:0]   i_prev,
   output delta_class_e o_cls,
   output logic [3:0]   o_mag
);

   logic [7:0] w_delta;
   logic [3:0] w_neg;

   assign w_delta = i_cin - i_prev;
   // Low nibble of the negated delta equals the negation of the low nibble.
   assign w_neg   = 4'd0 - w_delta[3:0];

   always_comb begin
      o_cls = DC_JUMP;
      o_mag = 4'd0;
      if (w_delta == 8'd0) begin
         o_cls = DC_HOLD;
      end else if (int'(w_delta) <= STEP_MAX) begin
         o_cls = DC_UP;
         o_mag = w_delta[3:0];
      end else if (int'(w_delta) >= 256 - STEP_MAX) begin
         o_cls = DC_DOWN;
         o_mag = w_neg;
      end
   end

endmodule

// File: rtl/count_monitor.sv
// Watches a sampled 8-bit counter, locks onto a constant step/direction and flags
// stalls, jumps and step errors; step errors are tallied in a saturating counter.
module count_monitor
   import count_mon_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int STEP_MAX = STEP_MAX_DEF
) (
   input  logic           clk,
   input  logic           reset,
   count_monitor_if.slave bus
);

   localparam logic [1:0] S_EMPTY = ST_EMPTY;
   localparam logic [1:0] S_SEED  = ST_SEED;
   localparam logic [1:0] S_ACQ   = ST_ACQ;
   localparam logic [1:0] S_LOCK  = ST_LOCK;
   localparam logic [3:0] LOCK_N  = 4'(LOCK_CNT);

   logic [1:0]   r_state;
   logic [7:0]   r_prev;
   logic [3:0]   r_cnt;
   logic [3:0]   r_step;
   logic         r_dir;
   logic         r_locked;
   logic         r_err;
   logic         r_jump;
   logic         r_stall;
   logic [7:0]   r_err_count;

   delta_class_e w_cls;
   logic [3:0]   w_mag;
   logic         w_is_step;
   logic         w_cls_dir;
   logic         w_match;
   logic [1:0]   w_nxt_state;
   logic [3:0]   w_nxt_cnt;
   logic [3:0]   w_nxt_step;
   logic         w_nxt_dir;
   logic         w_err;
   logic         w_jump;
   logic         w_stall;
   logic [7:0]   w_nxt_err_count;

   count_delta_class #(.STEP_MAX(STEP_MAX)) u_class (
      .i_cin  (bus.cin),
      .i_prev (r_prev),
      .o_cls  (w_cls),
      .o_mag  (w_mag)
   );

   assign w_is_step = (w_cls == DC_UP) || (w_cls == DC_DOWN);
   assign w_cls_dir = (w_cls == DC_DOWN);
   assign w_match   = w_is_step && (w_cls_dir == r_dir) && (w_mag == r_step);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_step  = r_step;
      w_nxt_dir   = r_dir;
      w_err       = 1'b0;
      w_jump      = 1'b0;
      w_stall     = 1'b0;
      if (bus.sample_en) begin
         case (r_state)
            S_EMPTY: w_nxt_state = S_SEED;
            S_SEED: begin
               if (w_is_step) begin
                  w_nxt_state = S_ACQ;
                  w_nxt_step  = w_mag;
                  w_nxt_dir   = w_cls_dir;
                  w_nxt_cnt   = 4'd1;
               end
            end
            S_ACQ: begin
               if (w_cls == DC_JUMP) begin
                  w_nxt_state = S_SEED;
                  w_nxt_step  = 4'd0;
                  w_nxt_dir   = 1'b0;
                  w_nxt_cnt   = 4'd0;
               end else if (w_match) begin
                  w_nxt_cnt = r_cnt + 4'd1;
                  if (r_cnt + 4'd1 == LOCK_N) w_nxt_state = S_LOCK;
               end else if (w_is_step) begin
                  w_nxt_step = w_mag;
                  w_nxt_dir  = w_cls_dir;
                  w_nxt_cnt  = 4'd1;
               end
            end
            default: begin
               // Locked: any departure from the confirmed step raises exactly one event.
               if (w_cls == DC_JUMP) begin
                  w_jump      = 1'b1;
                  w_nxt_state = S_SEED;
                  w_nxt_step  = 4'd0;
                  w_nxt_dir   = 1'b0;
                  w_nxt_cnt   = 4'd0;
               end else if (w_cls == DC_HOLD) begin
                  w_stall = 1'b1;
               end else if (!w_match) begin
                  w_err       = 1'b1;
                  w_nxt_state = S_ACQ;
                  w_nxt_step  = w_mag;
                  w_nxt_dir   = w_cls_dir;
                  w_nxt_cnt   = 4'd1;
               end
            end
         endcase
      end
   end

   always_comb begin
      w_nxt_err_count = r_err_count;
      if (bus.clr_err) begin
         w_nxt_err_count = {7'd0, w_err};
      end else if (w_err && (r_err_count != 8'hFF)) begin
         w_nxt_err_count = r_err_count + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_EMPTY;
         r_prev      <= 8'd0;
         r_cnt       <= 4'd0;
         r_step      <= 4'd0;
         r_dir       <= 1'b0;
         r_locked    <= 1'b0;
         r_err       <= 1'b0;
         r_jump      <= 1'b0;
         r_stall     <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         r_state     <= w_nxt_state;
         r_cnt       <= w_nxt_cnt;
         r_step      <= w_nxt_step;
         r_dir       <= w_nxt_dir;
         r_locked    <= (w_nxt_state == S_LOCK);
         r_err       <= w_err;
         r_jump      <= w_jump;
         r_stall     <= w_stall;
         r_err_count <= w_nxt_err_count;
         if (bus.sample_en) r_prev <= bus.cin;
      end
   end

   assign bus.step      = r_step;
   assign bus.dir       = r_dir;
   assign bus.locked    = r_locked;
   assign bus.err       = r_err;
   assign bus.jump      = r_jump;
   assign bus.stall     = r_stall;
   assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor: directed vector table, corner sequences and a
// randomized run against a signed-delta behavioural model.
module tb_count_monitor;

   localparam int LOCK_CNT = 4;
   localparam int STEP_MAX = 15;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   count_monitor_if bus ();

   count_monitor #(.LOCK_CNT(LOCK_CNT), .STEP_MAX(STEP_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: candidate is a signed step (0 = no candidate yet).
   int m_prev, m_cand, m_run, m_errc;
   bit m_have, m_lock, m_err, m_jump, m_stall;

   task automatic m_reset();
      m_prev = 0; m_cand = 0; m_run = 0; m_errc = 0;
      m_have = 0; m_lock = 0; m_err = 0; m_jump = 0; m_stall = 0;
   endtask

   task automatic m_sample(input int en, input int c, input int clr);
      m_err = 0; m_jump = 0; m_stall = 0;
      if (en != 0) begin
         if (!m_have) begin
            m_have = 1;
         end else begin
            int d;
            d = (c - m_prev) & 255;
            if (d >= 128) d -= 256;
            if (d == 0) begin
               if (m_lock) m_stall = 1;
            end else if (d > STEP_MAX || d < -STEP_MAX) begin
               if (m_lock) m_jump = 1;
               m_cand = 0; m_run = 0; m_lock = 0;
            end else if (m_cand == 0) begin
               m_cand = d; m_run = 1;
            end else if (d == m_cand) begin
               m_run++;
               if (m_run >= LOCK_CNT) m_lock = 1;
            end else begin
               if (m_lock) m_err = 1;
               m_lock = 0; m_cand = d; m_run = 1;
            end
         end
         m_prev = c & 255;
      end
      if (clr != 0) m_errc = m_err ? 1 : 0;
      else if (m_err && m_errc < 255) m_errc++;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d actual %0d expected %0d", name, cycle, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int st, input int dr, input int lk,
                          input int er, input int jp, input int sl, input int ec);
      chk({tag, ".step"},      int'(bus.step),      st);
      chk({tag, ".dir"},       int'(bus.dir),       dr);
      chk({tag, ".locked"},    int'(bus.locked),    lk);
      chk({tag, ".err"},       int'(bus.err),       er);
      chk({tag, ".jump"},      int'(bus.jump),      jp);
      chk({tag, ".stall"},     int'(bus.stall),     sl);
      chk({tag, ".err_count"}, int'(bus.err_count), ec);
   endtask

   task automatic chk_model(input string tag);
      chk_all(tag, (m_cand < 0) ? -m_cand : m_cand, (m_cand < 0) ? 1 : 0, int'(m_lock),
              int'(m_err), int'(m_jump), int'(m_stall), m_errc);
   endtask

   task automatic cyc(input int en, input int c, input int clr, input string tag);
      bus.sample_en = (en != 0);
      bus.cin       = 8'(c);
      bus.clr_err   = (clr != 0);
      @(posedge clk);
      cycle++;
      m_sample(en, c, clr);
      #1;
      chk_model(tag);
   endtask

   task automatic do_reset(input int en, input int c);
      bus.sample_en = (en != 0);
      bus.cin       = 8'(c);
      bus.clr_err   = 1'b0;
      reset         = 1'b1;
      @(posedge clk);
      cycle++;
      m_reset();
      #1;
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
   endtask

   typedef struct {
      int en; int c; int clr;
      int step; int dir; int lk; int err; int jmp; int stl; int ec;
   } vec_t;

   vec_t tbl [21];
   int   v;
   int   cur;
   int   s;

   initial begin
      bus.sample_en = 1'b0;
      bus.cin       = 8'd0;
      bus.clr_err   = 1'b0;
      reset         = 1'b1;
      m_reset();

      //          en  cin clr  step dir lk err jmp stl ec
      tbl[0]  = '{1,    0, 0,   0,  0,  0, 0,  0,  0,  0};
      tbl[1]  = '{1,    1, 0,   1,  0,  0, 0,  0,  0,  0};
      tbl[2]  = '{1,    2, 0,   1,  0,  0, 0,  0,  0,  0};
      tbl[3]  = '{1,    3, 0,   1,  0,  0, 0,  0,  0,  0};
      tbl[4]  = '{1,    4, 0,   1,  0,  1, 0,  0,  0,  0};
      tbl[5]  = '{0,   99, 0,   1,  0,  1, 0,  0,  0,  0};
      tbl[6]  = '{1,    5, 0,   1,  0,  1, 0,  0,  0,  0};
      tbl[7]  = '{1,    5, 0,   1,  0,  1, 0,  0,  1,  0};
      tbl[8]  = '{1,    7, 0,   2,  0,  0, 1,  0,  0,  1};
      tbl[9]  = '{1,    9, 0,   2,  0,  0, 0,  0,  0,  1};
      tbl[10] = '{1,   11, 0,   2,  0,  0, 0,  0,  0,  1};
      tbl[11] = '{1,   13, 0,   2,  0,  1, 0,  0,  0,  1};
      tbl[12] = '{1,   10, 0,   3,  1,  0, 1,  0,  0,  2};
      tbl[13] = '{1,    7, 0,   3,  1,  0, 0,  0,  0,  2};
      tbl[14] = '{1,    4, 0,   3,  1,  0, 0,  0,  0,  2};
      tbl[15] = '{1,    1, 0,   3,  1,  1, 0,  0,  0,  2};
      tbl[16] = '{1,  254, 0,   3,  1,  1, 0,  0,  0,  2};
      tbl[17] = '{1,  100, 0,   0,  0,  0, 0,  1,  0,  2};
      tbl[18] = '{1,  101, 0,   1,  0,  0, 0,  0,  0,  2};
      tbl[19] = '{0,    0, 1,   1,  0,  0, 0,  0,  0,  0};
      tbl[20] = '{1,  102, 0,   1,  0,  0, 0,  0,  0,  0};

      repeat (2) @(posedge clk);
      do_reset(0, 0);

      for (int i = 0; i < 21; i++) begin
         bus.sample_en = (tbl[i].en != 0);
         bus.cin       = 8'(tbl[i].c);
         bus.clr_err   = (tbl[i].clr != 0);
         @(posedge clk);
         cycle++;
         #1;
         chk_all($sformatf("tbl%0d", i), tbl[i].step, tbl[i].dir, tbl[i].lk,
                 tbl[i].err, tbl[i].jmp, tbl[i].stl, tbl[i].ec);
      end

      // Up-lock at step 3 carried across the 255 -> 0 wrap.
      do_reset(1, 0);
      for (int i = 0; i < 5; i++) cyc(1, 238 + 3 * i, 0, "wrap_acq");
      chk("wrap_locked_start", int'(bus.locked), 1);
      cyc(1, 253, 0, "wrap");
      cyc(1, 0, 0, "wrap");
      cyc(0, 77, 0, "wrap_idle");
      cyc(1, 3, 0, "wrap");
      chk("wrap_locked_end", int'(bus.locked), 1);
      chk("wrap_no_err", int'(bus.err_count), 0);

      // Jump out of lock, second jump in seed, then relock.
      do_reset(1, 0);
      for (int i = 10; i < 15; i++) cyc(1, i, 0, "jmp_acq");
      cyc(1, 40, 0, "jmp");
      chk("jump_pulse", int'(bus.jump), 1);
      chk("jump_unlock", int'(bus.locked), 0);
      cyc(1, 5, 0, "jmp_seed");
      chk("jump_pulse_one", int'(bus.jump), 0);
      for (int i = 6; i <= 10; i++) cyc(1, i, 0, "relock");
      chk("relocked", int'(bus.locked), 1);

      // Saturate err_count, then clear coincident with an error.
      do_reset(1, 0);
      v = 0;
      cyc(1, v, 0, "sat_seed");
      for (int i = 0; i < 4; i++) begin v += 1; cyc(1, v & 255, 0, "sat_lock"); end
      for (int k = 0; k < 300; k++) begin
         for (int j = 0; j < 4; j++) begin
            v += (k % 2 == 0) ? 2 : 1;
            cyc(1, v & 255, 0, "sat");
         end
      end
      chk("errcnt_saturated", int'(bus.err_count), 255);
      v += 2;
      cyc(1, v & 255, 1, "clr_err");
      chk("clr_with_err_pulse", int'(bus.err), 1);
      chk("clr_with_err_count", int'(bus.err_count), 1);

      // Reset while locked, idle cycles, then a fresh first sample.
      for (int i = 0; i < 5; i++) cyc(1, 60 + i, 0, "pre_rst");
      chk("pre_rst_locked", int'(bus.locked), 1);
      do_reset(1, 200);
      cyc(0, 5, 0, "post_rst_idle");
      cyc(1, 77, 0, "post_rst_first");
      cyc(1, 78, 0, "post_rst_second");
      chk("post_rst_step", int'(bus.step), 1);

      // Randomized run against the model.
      cur = 0;
      s   = 1;
      for (int n = 0; n < 3000; n++) begin
         int k, en, clr;
         k   = int'($urandom_range(0, 99));
         en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
         clr = ($urandom_range(0, 63) == 0) ? 1 : 0;
         if (k < 65) cur = cur + s;
         else if (k < 72) cur = cur;
         else if (k < 82) begin
            s   = int'($urandom_range(0, 2 * STEP_MAX)) - STEP_MAX;
            cur = cur + s;
         end else if (k < 90) cur = int'($urandom_range(0, 255));
         else cur = cur + int'($urandom_range(0, 40)) - 20;
         cur = cur & 255;
         if ($urandom_range(0, 499) == 0) do_reset(en, cur);
         else cyc(en, cur, clr, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
